// File: rtl/shift_register_32_ctrl.sv
// shift_register_32_ctrl
//   Load sequencer for a serial-in shift register. A parallel word is accepted
//   on a valid/ready handshake. It is then serialised onto sr_data with a
//   per-bit enable (sr_en). After WIDTH shifts, done pulses for one cycle.
//   An internal mirror tracks what the shift register holds, so the last
//   completed word can be read back on out_word.
//
//   Build option: define SHIFT_LSB_FIRST_EN to serialise LSB-first. out_word
//   then ends up as the bit-reversed input word. The default is MSB-first,
//   where out_word equals in_data.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous reset, active-high
//   in_valid  in   host offers in_data
//   in_data   in   parallel word to shift out
//   in_ready  out  word can be accepted (IDLE only)
//   pause     in   hold shifting for this cycle
//   abort     in   abandon the current load
//   sr_data   out  serial bit to the shift register
//   sr_en     out  shift enable for the shift register
//   busy      out  high in SHIFT and DONE
//   bit_cnt   out  bits shifted so far in the current load
//   done      out  one-cycle completion pulse
//   out_word  out  shift register contents after the last completed load
//
// state | meaning
// IDLE  | waiting for a word, in_ready high
// SHIFT | serialising, one bit per cycle unless paused or aborted
// DONE  | single cycle, done high, out_word valid
module shift_register_32_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             pause,
  input  logic             abort,
  output logic             sr_data,
  output logic             sr_en,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             done,
  output logic [WIDTH-1:0] out_word
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] buffer;
  logic [WIDTH-1:0] buffer_shifted;
  logic [WIDTH-1:0] mirror;
  logic [WIDTH-1:0] mirror_nxt;
  logic             accept;
  logic             last_shift;

  assign accept     = in_valid & in_ready;
  assign last_shift = sr_en & (bit_cnt == LAST_BIT);

`ifdef SHIFT_LSB_FIRST_EN
  assign sr_data        = buffer[0];
  assign buffer_shifted = {1'b0, buffer[WIDTH-1:1]};
`else
  assign sr_data        = buffer[WIDTH-1];
  assign buffer_shifted = {buffer[WIDTH-2:0], 1'b0};
`endif

  // The mirror sees exactly what the shift register sees: each enabled edge
  // shifts the current sr_data into its LSB.
  assign mirror_nxt = {mirror[WIDTH-2:0], sr_data};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT: begin
        if (abort)           state_nxt = IDLE;
        else if (last_shift) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs. sr_en is combinational from the inputs, so pause, abort and
  // reset take effect in the same cycle they are asserted.
  always_comb begin
    in_ready = (state == IDLE);
    busy     = (state == SHIFT) || (state == DONE);
    done     = (state == DONE);
    sr_en    = (state == SHIFT) && !pause && !abort;
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buffer   <= '0;
      mirror   <= '0;
      bit_cnt  <= '0;
      out_word <= '0;
    end else if (accept) begin
      buffer  <= in_data;
      bit_cnt <= '0;
    end else if (sr_en) begin
      buffer  <= buffer_shifted;
      mirror  <= mirror_nxt;
      bit_cnt <= bit_cnt + CNT_ONE;
      // Capture the post-shift mirror on the edge that enters DONE.
      if (last_shift) out_word <= mirror_nxt;
    end else if ((state == SHIFT && abort) || state == DONE) begin
      bit_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_shift_register_32_ctrl.sv
// Testbench for shift_register_32_ctrl.
// The driver issues loads and pushes expectations into queues:
//   - serial bits, in order;
//   - completion records (word and cycle).
// A negedge monitor pops and compares whenever the DUT shifts or pulses done.
module tb_shift_register_32_ctrl;
  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             pause = 1'b0;
  logic             abort = 1'b0;
  logic             in_ready, sr_data, sr_en, busy, done;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] out_word;

  shift_register_32_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .pause(pause), .abort(abort), .sr_data(sr_data),
    .sr_en(sr_en), .busy(busy), .bit_cnt(bit_cnt), .done(done),
    .out_word(out_word)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] word;
    int               at;
  } done_t;

  bit    exp_bits[$];
  done_t exp_done[$];
  logic [WIDTH-1:0] last_word = '0;
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [WIDTH-1:0] reverse(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
    return r;
  endfunction

  // Reference: order of bits on the wire and the word left in the register.
  function automatic bit nth_bit(input logic [WIDTH-1:0] d, input int i);
`ifdef SHIFT_LSB_FIRST_EN
    return d[i];
`else
    return d[WIDTH-1-i];
`endif
  endfunction

  function automatic logic [WIDTH-1:0] exp_word(input logic [WIDTH-1:0] d);
`ifdef SHIFT_LSB_FIRST_EN
    return reverse(d);
`else
    return d;
`endif
  endfunction

  // Monitor
  bit    mon_b;
  done_t mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      if (sr_en) begin
        if (exp_bits.size() == 0) chk("unexpected_shift", 1, 0);
        else begin
          mon_b = exp_bits.pop_front();
          chk("sr_data", sr_data, mon_b);
        end
      end
      if (done) begin
        if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          mon_e = exp_done.pop_front();
          chk("out_word", out_word, mon_e.word);
          chk("done_cycle", cyc, mon_e.at);
        end
      end
    end
  end

  // Called at #1 after a posedge while the DUT is expected in IDLE.
  // abort_at: shift index at which abort is raised (-1 for none).
  // fmask: bit k set forces one pause cycle before bit k is shifted.
  task automatic load(input logic [WIDTH-1:0] d, input int abort_at, input int pause_pct,
                      input bit [WIDTH-1:0] fmask, input bit hold_junk,
                      input bit chain, input logic [WIDTH-1:0] nxt);
    int k, np, acc, iter;
    bit p, a, aborted;
    bit [WIDTH-1:0] fdone;
    chk("idle_in_ready", in_ready, 1);
    chk("idle_busy", busy, 0);
    in_valid = 1'b1;
    in_data  = d;
    pause    = 1'($urandom_range(1));
    abort    = 1'($urandom_range(1));
    #1 chk("idle_sr_en", sr_en, 0);
    @(posedge clk); #1;
    acc = cyc - 1;
    k = 0; np = 0; iter = 0; aborted = 0; fdone = '0;
    forever begin
      chk("bit_cnt", bit_cnt, k);
      chk("shift_busy", busy, 1);
      chk("shift_in_ready", in_ready, 0);
      chk("shift_done", done, 0);
      a = (k == abort_at);
      p = (fmask[k] && !fdone[k]) || ($urandom_range(99) < pause_pct)
          || (a && $urandom_range(1) == 1);
      if (p) fdone[k] = 1'b1;
      pause = p;
      abort = a;
      if (hold_junk) begin
        in_valid = 1'b1;
        in_data  = nxt;
      end else begin
        in_valid = 1'($urandom_range(1));
        in_data  = $urandom;
      end
      #1 chk("sr_en", sr_en, !p && !a);
      if (!p && !a) exp_bits.push_back(nth_bit(d, k));
      if (p && !a) np++;
      @(posedge clk); #1;
      if (a) begin
        aborted = 1;
        break;
      end
      if (!p) k++;
      if (k == WIDTH) break;
      iter++;
      if (iter > 2000) begin
        chk("shift_timeout", 0, 1);
        break;
      end
    end
    if (aborted) begin
      chk("abort_in_ready", in_ready, 1);
      chk("abort_busy", busy, 0);
      chk("abort_bit_cnt", bit_cnt, 0);
      chk("abort_out_word", out_word, last_word);
      in_valid = chain;
      in_data  = nxt;
      pause = 1'b0;
      abort = 1'b0;
    end else begin
      exp_done.push_back(done_t'{exp_word(d), acc + WIDTH + 1 + np});
      chk("done_bit_cnt", bit_cnt, WIDTH);
      chk("done_busy", busy, 1);
      chk("done_in_ready", in_ready, 0);
      pause    = 1'($urandom_range(1));
      abort    = 1'($urandom_range(1));
      in_valid = chain;
      in_data  = chain ? nxt : $urandom;
      #1 chk("done_sr_en", sr_en, 0);
      last_word = exp_word(d);
      @(posedge clk); #1;
      chk("post_done_bit_cnt", bit_cnt, 0);
      chk("post_done_out_word", out_word, last_word);
      if (!chain) in_valid = 1'b0;
      pause = 1'b0;
      abort = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] d, nxt;
    bit [WIDTH-1:0] m;
    bit ch, prev_ch;
    int ab;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_bit_cnt", bit_cnt, 0);
    chk("rst_out_word", out_word, 0);
    chk("rst_sr_en", sr_en, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed: plain load, forced pauses, abort+pause, back-to-back with held valid
    load(32'h720EAFF2, -1, 0, '0, 0, 0, '0);
    m = '0; m[5] = 1'b1; m[20] = 1'b1;
    load(32'h80000001, -1, 0, m, 0, 0, '0);
    m = '0; m[10] = 1'b1;
    load(32'hFFFFFFFF, 10, 0, m, 0, 0, '0);
    load(32'hA5A5A5A5, -1, 0, '0, 1, 1, 32'h12345678);
    load(32'h12345678, -1, 0, '0, 0, 0, '0);
    load(32'h00000001, -1, 0, '0, 0, 0, '0);
    load(32'hC3C3C3C3, WIDTH - 1, 0, '0, 0, 0, '0);
    load(32'h0F0F0F0F, 0, 0, '0, 0, 0, '0);

    // Randomised loads, some chained back-to-back
    prev_ch = 0;
    nxt = $urandom;
    for (int i = 0; i < 24; i++) begin
      d   = prev_ch ? nxt : $urandom;
      ab  = ($urandom_range(3) == 0) ? int'($urandom_range(WIDTH - 1)) : -1;
      ch  = ($urandom_range(2) == 0);
      nxt = $urandom;
      load(d, ab, $urandom_range(30), '0, 1'($urandom_range(1)), ch, nxt);
      prev_ch = ch;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a load
    d = 32'hDEADBEEF;
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_bits.push_back(nth_bit(d, i));
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk("midrst_sr_en", sr_en, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_bit_cnt", bit_cnt, 0);
    chk("midrst_out_word", out_word, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_word = '0;
    @(posedge clk); #1;
    load(32'h13579BDF, -1, 10, '0, 0, 0, '0);

    repeat (3) @(posedge clk);
    #1;
    chk("bits_left", exp_bits.size(), 0);
    chk("dones_left", exp_done.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
